// File: rtl/fabric_config_pkg.sv
// Shared definitions for the fabric configuration path:
// controller states, default sync word and header field layout.
package fabric_config_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_ADDR,
        ST_DATA,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam logic [31:0] SYNC_WORD_DEF  = 32'hFAB0_FAB1;
    localparam int          FRAME_WORDS_DEF = 4;
    localparam int          ADDR_W_DEF      = 16;
    localparam int          MAX_FRAMES_DEF  = 1024;

    localparam int HDR_NFRM_LSB = 16;
    localparam int HDR_NFRM_W   = 16;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fabric_config_if.sv
// Word-source, frame-writer and status bundle of the
// fabric configuration controller.
interface fabric_config_if #(
    parameter int ADDR_W      = 16,
    parameter int FRAME_WORDS = 4
);
    logic [31:0]               src0_data_i;
    logic                      src0_valid_i;
    logic [31:0]               src1_data_i;
    logic                      src1_valid_i;
    logic                      src0_enable_o;
    logic                      src1_enable_o;
    logic                      abort_i;
    logic [ADDR_W-1:0]         frame_addr_o;
    logic [FRAME_WORDS*32-1:0] frame_data_o;
    logic                      frame_strobe_o;
    logic                      busy_o;
    logic                      owner_o;
    logic                      done_o;
    logic                      error_o;

    modport slave (
        input  src0_data_i, src0_valid_i,
        input  src1_data_i, src1_valid_i,
        input  abort_i,
        output src0_enable_o, src1_enable_o,
        output frame_addr_o, frame_data_o, frame_strobe_o,
        output busy_o, owner_o, done_o, error_o
    );

    modport master (
        output src0_data_i, src0_valid_i,
        output src1_data_i, src1_valid_i,
        output abort_i,
        input  src0_enable_o, src1_enable_o,
        input  frame_addr_o, frame_data_o, frame_strobe_o,
        input  busy_o, owner_o, done_o, error_o
    );

endinterface

// File: rtl/fabric_config_src_arbiter.sv
// Locks onto the first source presenting a sync word and muxes
// that source's word stream; src0 wins a same-cycle tie.
module fabric_config_src_arbiter
    import fabric_config_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD = SYNC_WORD_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        idle_i,
    input  logic        err_i,
    input  logic        abort_i,
    input  logic [31:0] src0_data_i,
    input  logic        src0_valid_i,
    input  logic [31:0] src1_data_i,
    input  logic        src1_valid_i,
    output logic        lock_o,
    output logic        owner_o,
    output logic        src0_enable_o,
    output logic        src1_enable_o,
    output logic [31:0] word_o,
    output logic        valid_o
);

    logic sync0;
    logic sync1;
    logic owner_q;
    logic owner_d;

    assign sync0   = src0_valid_i && (src0_data_i == SYNC_WORD);
    assign sync1   = src1_valid_i && (src1_data_i == SYNC_WORD);
    assign lock_o  = idle_i && !abort_i && (sync0 || sync1);
    assign owner_d = lock_o ? !sync0 : owner_q;
    assign owner_o = owner_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q <= 1'b0;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        src0_enable_o = 1'b1;
        src1_enable_o = 1'b1;
        if (err_i) begin
            src0_enable_o = 1'b0;
            src1_enable_o = 1'b0;
        end else if (!idle_i) begin
            src0_enable_o = !owner_q;
            src1_enable_o = owner_q;
        end
    end

    assign word_o  = owner_q ? src1_data_i : src0_data_i;
    assign valid_o = owner_q ? src1_valid_i : src0_valid_i;

endmodule

// File: rtl/fabric_config_controller.sv
// Bitstream parser: header, address and data words are assembled
// into frames that are strobed to the fabric frame writer.
module fabric_config_controller
    import fabric_config_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD   = SYNC_WORD_DEF,
    parameter int          FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int          ADDR_W      = ADDR_W_DEF,
    parameter int          MAX_FRAMES  = MAX_FRAMES_DEF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    fabric_config_if.slave cfg
);

    localparam int FCW = $clog2(MAX_FRAMES + 1);
    localparam int WCW = cnt_w(FRAME_WORDS);
    localparam int FDW = FRAME_WORDS * 32;

    state_e            state_q, state_d;
    logic [FCW-1:0]    frm_q, frm_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] stg_addr_q, stg_addr_d;
    logic [FDW-1:0]    stg_data_q, stg_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [FDW-1:0]    out_data_q, out_data_d;
    logic              strobe_q, strobe_d;

    logic                  idle;
    logic                  busy;
    logic                  lock;
    logic                  owner;
    logic [31:0]           word;
    logic                  acc;
    logic [HDR_NFRM_W-1:0] nfrm;

    assign idle = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy = (state_q == ST_HEADER) || (state_q == ST_ADDR)
               || (state_q == ST_DATA);
    assign nfrm = word[HDR_NFRM_LSB +: HDR_NFRM_W];

    fabric_config_src_arbiter #(
        .SYNC_WORD (SYNC_WORD)
    ) u_arb (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .idle_i        (idle),
        .err_i         (state_q == ST_ERROR),
        .abort_i       (cfg.abort_i),
        .src0_data_i   (cfg.src0_data_i),
        .src0_valid_i  (cfg.src0_valid_i),
        .src1_data_i   (cfg.src1_data_i),
        .src1_valid_i  (cfg.src1_valid_i),
        .lock_o        (lock),
        .owner_o       (owner),
        .src0_enable_o (cfg.src0_enable_o),
        .src1_enable_o (cfg.src1_enable_o),
        .word_o        (word),
        .valid_o       (acc)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            frm_q      <= '0;
            wcnt_q     <= '0;
            stg_addr_q <= '0;
            stg_data_q <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            frm_q      <= frm_d;
            wcnt_q     <= wcnt_d;
            stg_addr_q <= stg_addr_d;
            stg_data_q <= stg_data_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            strobe_q   <= strobe_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        frm_d      = frm_q;
        wcnt_d     = wcnt_q;
        stg_addr_d = stg_addr_q;
        stg_data_d = stg_data_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        strobe_d   = 1'b0;
        if (cfg.abort_i) begin
            // abort beats any word in the same cycle
            state_d    = ST_IDLE;
            frm_d      = '0;
            wcnt_d     = '0;
            stg_data_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (lock) state_d = ST_HEADER;
                end
                ST_HEADER: begin
                    if (acc) begin
                        if (nfrm == '0 || int'(nfrm) > MAX_FRAMES) begin
                            state_d = ST_ERROR;
                        end else begin
                            frm_d   = FCW'(nfrm);
                            state_d = ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (acc) begin
                        stg_addr_d = word[ADDR_W-1:0];
                        wcnt_d     = '0;
                        state_d    = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (acc) begin
                        for (int i = 0; i < FRAME_WORDS; i++) begin
                            if (wcnt_q == WCW'(i)) stg_data_d[i*32 +: 32] = word;
                        end
                        if (int'(wcnt_q) == FRAME_WORDS - 1) begin
                            strobe_d   = 1'b1;
                            out_addr_d = stg_addr_q;
                            out_data_d = stg_data_d;
                            frm_d      = frm_q - FCW'(1);
                            state_d    = (frm_q == FCW'(1)) ? ST_DONE : ST_ADDR;
                        end else begin
                            wcnt_d = wcnt_q + WCW'(1);
                        end
                    end
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign cfg.frame_addr_o   = out_addr_q;
    assign cfg.frame_data_o   = out_data_q;
    assign cfg.frame_strobe_o = strobe_q;
    assign cfg.busy_o         = busy;
    assign cfg.owner_o        = busy && owner;
    assign cfg.done_o         = (state_q == ST_DONE);
    assign cfg.error_o        = (state_q == ST_ERROR);

endmodule

// File: tb/tb_fabric_config_controller.sv
// Directed and randomized bitstreams checked against a frame-level
// model of what the frame writer should receive.
module tb_fabric_config_controller;

    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
    localparam int          MAXF = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fabric_config_if #(.ADDR_W(16), .FRAME_WORDS(4)) bus ();

    fabric_config_controller #(
        .SYNC_WORD   (SYNC),
        .FRAME_WORDS (4),
        .ADDR_W      (16),
        .MAX_FRAMES  (MAXF)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .cfg   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [143:0] obs_q[$];
    logic [143:0] exp_q[$];
    logic [31:0]  wq[$];

    always @(negedge clk)
        if (bus.frame_strobe_o === 1'b1)
            obs_q.push_back({bus.frame_addr_o, bus.frame_data_o});

    task automatic chk(input string tag, input logic [143:0] o, input logic [143:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int src, input logic [31:0] w, input bit noise);
        logic [31:0] nw;
        logic        nv;
        nw = ($urandom_range(0, 3) == 0) ? SYNC : $urandom;
        nv = noise && ($urandom_range(0, 1) == 1);
        if (src == 0) begin
            bus.src0_valid_i = 1'b1; bus.src0_data_i = w;
            bus.src1_valid_i = nv;   bus.src1_data_i = nw;
        end else begin
            bus.src1_valid_i = 1'b1; bus.src1_data_i = w;
            bus.src0_valid_i = nv;   bus.src0_data_i = nw;
        end
        tick();
        bus.src0_valid_i = 1'b0;
        bus.src1_valid_i = 1'b0;
    endtask

    task automatic noise_cyc(input int src);
        bus.src0_valid_i = (src == 1) && ($urandom_range(0, 1) == 1);
        bus.src1_valid_i = (src == 0) && ($urandom_range(0, 1) == 1);
        bus.src0_data_i  = ($urandom_range(0, 3) == 0) ? SYNC : $urandom;
        bus.src1_data_i  = ($urandom_range(0, 3) == 0) ? SYNC : $urandom;
        tick();
        bus.src0_valid_i = 1'b0;
        bus.src1_valid_i = 1'b0;
    endtask

    // words of the stream after sync; idle gaps never follow the last word
    task automatic play(input int src, input int gapmax, input bit noise);
        logic [31:0] w;
        while (wq.size() != 0) begin
            w = wq.pop_front();
            drive(src, w, noise);
            if (gapmax > 0 && wq.size() != 0)
                repeat ($urandom_range(0, gapmax)) begin
                    if (noise) noise_cyc(src);
                    else tick();
                end
        end
    endtask

    task automatic hdr(input int n);
        logic [15:0] nn;
        nn = 16'(n);
        wq.push_back({nn, 16'($urandom)});
    endtask

    task automatic add_frame(input logic [31:0] aw, input logic [127:0] d);
        wq.push_back(aw);
        for (int i = 0; i < 4; i++) wq.push_back(d[i*32 +: 32]);
        exp_q.push_back({aw[15:0], d});
    endtask

    function automatic logic [31:0] rnd_word();
        return ($urandom_range(0, 7) == 0) ? SYNC : $urandom;
    endfunction

    task automatic check_frames(input string tag);
        int n;
        tick();
        tick();
        chk({tag, "_count"}, 144'(obs_q.size()), 144'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_frame%0d", tag, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic abort_pulse(input bit with_word, input int src, input logic [31:0] w);
        bus.abort_i = 1'b1;
        if (with_word) begin
            if (src == 0) begin bus.src0_valid_i = 1'b1; bus.src0_data_i = w; end
            else          begin bus.src1_valid_i = 1'b1; bus.src1_data_i = w; end
        end
        tick();
        bus.abort_i      = 1'b0;
        bus.src0_valid_i = 1'b0;
        bus.src1_valid_i = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_en0"},    144'(bus.src0_enable_o),  144'(1));
        chk({tag, "_en1"},    144'(bus.src1_enable_o),  144'(1));
        chk({tag, "_busy"},   144'(bus.busy_o),         144'(0));
        chk({tag, "_owner"},  144'(bus.owner_o),        144'(0));
        chk({tag, "_done"},   144'(bus.done_o),         144'(0));
        chk({tag, "_error"},  144'(bus.error_o),        144'(0));
        chk({tag, "_strobe"}, 144'(bus.frame_strobe_o), 144'(0));
        chk({tag, "_addr"},   144'(bus.frame_addr_o),   144'(0));
        chk({tag, "_data"},   144'(bus.frame_data_o),   144'(0));
    endtask

    initial begin
        logic [127:0] d;
        int           src;
        int           n;

        bus.src0_data_i  = '0;
        bus.src0_valid_i = 1'b0;
        bus.src1_data_i  = '0;
        bus.src1_valid_i = 1'b0;
        bus.abort_i      = 1'b0;

        // reset values
        repeat (3) tick();
        chk_reset_vals("rst");
        @(negedge clk);
        rst = 1'b0;
        tick();

        // single frame via src0, plus strobe latency
        drive(0, SYNC, 0);
        chk("t1_busy",  144'(bus.busy_o),        144'(1));
        chk("t1_owner", 144'(bus.owner_o),       144'(0));
        chk("t1_en1",   144'(bus.src1_enable_o), 144'(0));
        chk("t1_en0",   144'(bus.src0_enable_o), 144'(1));
        wq.push_back(32'h0001_0000);
        add_frame(32'h12, {32'd4, 32'd3, 32'd2, 32'd1});
        play(0, 0, 0);
        chk("t1_strobe_lat", 144'(bus.frame_strobe_o), 144'(1));
        chk("t1_addr", 144'(bus.frame_addr_o), 144'(16'h12));
        check_frames("t1");
        chk("t1_done",   144'(bus.done_o), 144'(1));
        chk("t1_nobusy", 144'(bus.busy_o), 144'(0));
        chk("t1_hold", 144'(bus.frame_data_o), 144'({32'd4, 32'd3, 32'd2, 32'd1}));

        // three frames back to back via src1 from DONE
        drive(1, SYNC, 0);
        chk("t2_done_clr", 144'(bus.done_o),        144'(0));
        chk("t2_owner",    144'(bus.owner_o),       144'(1));
        chk("t2_en0",      144'(bus.src0_enable_o), 144'(0));
        hdr(3);
        for (int i = 0; i < 3; i++)
            add_frame($urandom, {$urandom, $urandom, $urandom, $urandom});
        play(1, 0, 0);
        check_frames("t2");
        chk("t2_done", 144'(bus.done_o), 144'(1));

        // same-cycle sync on both sources
        bus.src0_valid_i = 1'b1; bus.src0_data_i = SYNC;
        bus.src1_valid_i = 1'b1; bus.src1_data_i = SYNC;
        tick();
        bus.src0_valid_i = 1'b0;
        bus.src1_valid_i = 1'b0;
        chk("t3_owner", 144'(bus.owner_o),       144'(0));
        chk("t3_en1",   144'(bus.src1_enable_o), 144'(0));
        hdr(2);
        for (int i = 0; i < 2; i++)
            add_frame($urandom, {rnd_word(), rnd_word(), rnd_word(), rnd_word()});
        play(0, 2, 1);
        check_frames("t3");
        chk("t3_done", 144'(bus.done_o), 144'(1));

        // header N=0 -> error, sticky, enables off
        drive(0, SYNC, 0);
        drive(0, 32'h0000_ABCD, 0);
        chk("t4_err",  144'(bus.error_o),       144'(1));
        chk("t4_en0",  144'(bus.src0_enable_o), 144'(0));
        chk("t4_en1",  144'(bus.src1_enable_o), 144'(0));
        chk("t4_busy", 144'(bus.busy_o),        144'(0));
        drive(0, SYNC, 1);
        for (int i = 0; i < 6; i++) drive(i % 2, rnd_word(), 1);
        chk("t4_sticky", 144'(bus.error_o), 144'(1));
        check_frames("t4");
        abort_pulse(0, 0, '0);
        chk("t4_abort_err",  144'(bus.error_o), 144'(0));
        chk("t4_abort_busy", 144'(bus.busy_o),  144'(0));
        chk("t4_abort_en0",  144'(bus.src0_enable_o), 144'(1));
        chk("t4_abort_en1",  144'(bus.src1_enable_o), 144'(1));

        // header N=MAX+1 -> error; N=MAX is legal
        drive(1, SYNC, 0);
        drive(1, {16'(MAXF + 1), 16'h0}, 0);
        chk("t5_err", 144'(bus.error_o), 144'(1));
        abort_pulse(0, 0, '0);
        drive(1, SYNC, 0);
        drive(1, {16'(MAXF), 16'h0}, 0);
        chk("t5_max_err",  144'(bus.error_o), 144'(0));
        chk("t5_max_busy", 144'(bus.busy_o),  144'(1));
        abort_pulse(0, 0, '0);
        chk("t5_idle", 144'(bus.busy_o), 144'(0));

        // abort after 2 of 4 data words, word in abort cycle ignored
        drive(0, SYNC, 0);
        drive(0, 32'h0001_0000, 0);
        drive(0, 32'h0000_0777, 0);
        drive(0, 32'hDEAD_0001, 0);
        drive(0, 32'hDEAD_0002, 0);
        abort_pulse(1, 0, 32'hDEAD_0003);
        chk("t6_busy", 144'(bus.busy_o), 144'(0));
        drive(0, 32'hDEAD_0004, 0);
        drive(1, SYNC, 0);
        hdr(1);
        add_frame(32'h0000_0055, {$urandom, $urandom, $urandom, $urandom});
        play(1, 1, 1);
        check_frames("t6");

        // reset mid-DATA
        drive(0, SYNC, 0);
        drive(0, 32'h0001_0000, 0);
        drive(0, 32'h0000_0099, 0);
        drive(0, 32'hBEEF_0001, 0);
        drive(0, 32'hBEEF_0002, 0);
        chk("t7_busy", 144'(bus.busy_o), 144'(1));
        bus.src0_valid_i = 1'b1;
        bus.src0_data_i  = 32'hBEEF_0003;
        rst = 1'b1;
        #1;
        chk_reset_vals("t7");
        @(negedge clk);
        bus.src0_valid_i = 1'b0;
        rst = 1'b0;
        tick();
        drive(0, 32'hBEEF_0004, 0);
        drive(0, 32'hBEEF_0005, 0);
        check_frames("t7");
        chk("t7_after_busy", 144'(bus.busy_o), 144'(0));

        // randomized bitstreams, relocking from DONE each time
        for (int k = 0; k < 8; k++) begin
            src = $urandom_range(0, 1);
            n   = $urandom_range(1, 4);
            drive(src, SYNC, 0);
            chk($sformatf("r%0d_owner", k), 144'(bus.owner_o), 144'(src));
            chk($sformatf("r%0d_done_clr", k), 144'(bus.done_o), 144'(0));
            hdr(n);
            for (int i = 0; i < n; i++) begin
                d = {rnd_word(), rnd_word(), rnd_word(), rnd_word()};
                add_frame(rnd_word(), d);
            end
            play(src, $urandom_range(0, 3), 1);
            check_frames($sformatf("r%0d", k));
            chk($sformatf("r%0d_done", k), 144'(bus.done_o), 144'(1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
